// File: rtl/psram_arbiter_if.sv
// Bus bundle between the PSRAM arbiter and its requesters, SNES timing inputs and PSRAM port.
// The slave modport is the arbiter side and the master modport is the requester/environment side.
interface psram_arbiter_if;
    logic        snes_cpu_clk;
    logic        snes_cycle_start;
    logic        snes_cycle_end;
    logic        snes_rom_hit;
    logic        mcu_rrq;
    logic        mcu_wrq;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata;
    logic        mcu_rdy;
    logic [7:0]  mcu_rdata;
    logic        dma_wrq;
    logic [23:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [15:0] rom_data_in;
    logic        arb_hit;
    logic        arb_we;
    logic [23:0] arb_addr;
    logic [7:0]  arb_wdata;
    logic        snes_dead;

    modport slave (
        input  snes_cpu_clk, snes_cycle_start, snes_cycle_end, snes_rom_hit,
        input  mcu_rrq, mcu_wrq, mcu_addr, mcu_wdata,
        input  dma_wrq, dma_addr, dma_wdata, rom_data_in,
        output mcu_rdy, mcu_rdata, dma_ack,
        output arb_hit, arb_we, arb_addr, arb_wdata, snes_dead
    );

    modport master (
        output snes_cpu_clk, snes_cycle_start, snes_cycle_end, snes_rom_hit,
        output mcu_rrq, mcu_wrq, mcu_addr, mcu_wdata,
        output dma_wrq, dma_addr, dma_wdata, rom_data_in,
        input  mcu_rdy, mcu_rdata, dma_ack,
        input  arb_hit, arb_we, arb_addr, arb_wdata, snes_dead
    );
endinterface

// File: rtl/psram_arbiter.sv
// Slots MCU (and optionally SD-DMA) PSRAM accesses into gaps left by the SNES CPU.
// Define PSRAM_ARB_DMA_EN to add the DMA write requester with round-robin arbitration.
module psram_arbiter #(
    parameter logic [3:0]  ROM_CYCLE_LEN = 4'd7,
    parameter logic [17:0] DEAD_TIMEOUT  = 18'd96000
) (
    input  logic               clk,
    input  logic               rst,
    psram_arbiter_if.slave     bus
);
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        RD_ACC = 4'b0010,
        WR_ACC = 4'b0100,
        END    = 4'b1000
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        owner_dma;
    logic        arb_hit_r, arb_we_r, dma_ack_r;
    logic [23:0] arb_addr_r;
    logic [7:0]  arb_wdata_r, mcu_rdata_r;

    logic        mcu_pend, mcu_we_r;
    logic [23:0] mcu_addr_r;
    logic [7:0]  mcu_wdata_r;

    logic        dma_pend, grant_dma;
    logic [23:0] gnt_addr;
    logic [7:0]  gnt_wdata;
    logic        gnt_we;

    logic        cycle_start_d;
    logic [17:0] dead_cnt;
    logic        snes_dead_r;

    logic free_slot, abort, start, mcu_done;

    assign abort     = snes_dead_r & bus.snes_cpu_clk;
    assign free_slot = bus.snes_cycle_end | (cycle_start_d & ~bus.snes_rom_hit) | snes_dead_r;
    assign start     = (state == IDLE) & free_slot & (mcu_pend | dma_pend) & ~abort;
    assign mcu_done  = (state == END) & ~abort & ~owner_dma;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_start_d <= 1'b0;
            dead_cnt      <= '0;
            snes_dead_r   <= 1'b1;
        end else begin
            cycle_start_d <= bus.snes_cycle_start;
            if (bus.snes_cpu_clk) begin
                dead_cnt    <= '0;
                snes_dead_r <= 1'b0;
            end else begin
                if (dead_cnt != '1) dead_cnt <= dead_cnt + 18'd1;
                if (dead_cnt > DEAD_TIMEOUT) snes_dead_r <= 1'b1;
            end
        end
    end

    // A read strobe wins over a simultaneous write strobe; the write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcu_pend    <= 1'b0;
            mcu_we_r    <= 1'b0;
            mcu_addr_r  <= '0;
            mcu_wdata_r <= '0;
        end else if (!mcu_pend && (bus.mcu_rrq || bus.mcu_wrq)) begin
            mcu_pend    <= 1'b1;
            mcu_we_r    <= ~bus.mcu_rrq;
            mcu_addr_r  <= bus.mcu_addr;
            mcu_wdata_r <= bus.mcu_wdata;
        end else if (mcu_done) begin
            mcu_pend    <= 1'b0;
        end
    end

`ifdef PSRAM_ARB_DMA_EN
    logic        last_dma;
    logic        dma_done;
    logic [23:0] dma_addr_r;
    logic [7:0]  dma_wdata_r;

    assign dma_done  = (state == END) & ~abort & owner_dma;
    assign grant_dma = dma_pend & (~mcu_pend | ~last_dma);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_pend    <= 1'b0;
            dma_addr_r  <= '0;
            dma_wdata_r <= '0;
        end else if (!dma_pend && bus.dma_wrq) begin
            dma_pend    <= 1'b1;
            dma_addr_r  <= bus.dma_addr;
            dma_wdata_r <= bus.dma_wdata;
        end else if (dma_done) begin
            dma_pend    <= 1'b0;
        end
    end

    // Reset value of DMA makes the MCU win the first contested slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_dma <= 1'b1;
        else if (start) last_dma <= grant_dma;
    end

    always_comb begin
        gnt_addr  = mcu_addr_r;
        gnt_wdata = mcu_wdata_r;
        gnt_we    = mcu_we_r;
        if (grant_dma) begin
            gnt_addr  = dma_addr_r;
            gnt_wdata = dma_wdata_r;
            gnt_we    = 1'b1;
        end
    end

    assign bus.dma_ack = dma_ack_r;
`else
    wire unused_dma = ^{bus.dma_wrq, bus.dma_addr, bus.dma_wdata, dma_ack_r};

    assign dma_pend    = 1'b0;
    assign grant_dma   = 1'b0;
    assign gnt_addr    = mcu_addr_r;
    assign gnt_wdata   = mcu_wdata_r;
    assign gnt_we      = mcu_we_r;
    assign bus.dma_ack = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_dma   <= 1'b0;
            arb_hit_r   <= 1'b0;
            arb_we_r    <= 1'b0;
            arb_addr_r  <= '0;
            arb_wdata_r <= '0;
            mcu_rdata_r <= '0;
            dma_ack_r   <= 1'b0;
        end else begin
            dma_ack_r <= 1'b0;
            // NOTE: abort is tested ahead of the case so it overrides every state, END included,
            // which is what keeps an aborted access from signalling completion.
            if (abort) begin
                state     <= IDLE;
                arb_hit_r <= 1'b0;
                arb_we_r  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (start) begin
                        owner_dma   <= grant_dma;
                        cnt         <= ROM_CYCLE_LEN;
                        arb_hit_r   <= 1'b1;
                        arb_we_r    <= gnt_we;
                        arb_addr_r  <= gnt_addr;
                        arb_wdata_r <= gnt_wdata;
                        state       <= gnt_we ? WR_ACC : RD_ACC;
                    end
                    RD_ACC, WR_ACC: begin
                        if (state == RD_ACC)
                            mcu_rdata_r <= arb_addr_r[0] ? bus.rom_data_in[7:0] : bus.rom_data_in[15:8];
                        if (cnt == 4'd0) begin
                            state     <= END;
                            arb_hit_r <= 1'b0;
                            arb_we_r  <= 1'b0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    END: begin
                        state     <= IDLE;
                        dma_ack_r <= owner_dma;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.mcu_rdy   = ~mcu_pend;
    assign bus.mcu_rdata = mcu_rdata_r;
    assign bus.arb_hit   = arb_hit_r;
    assign bus.arb_we    = arb_we_r;
    assign bus.arb_addr  = arb_addr_r;
    assign bus.arb_wdata = arb_wdata_r;
    assign bus.snes_dead = snes_dead_r;
endmodule
